oflow_history_line_reader: RTL and testbench
============================================

OFLOW_HISTORY_LINE_READER -- requirements
Module: oflow_history_line_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one stored bbox feature word.
REQ-002 SHALL have parameter TOTAL_FRAME_NUM_WIDTH, default 8, frame serial number width.
REQ-003 SHALL have parameter NUM_OF_HISTORY_FRAMES_WIDTH, default 3, fallback count width.
REQ-004 SHALL have parameter NUM_OF_BBOX_IN_FRAME_WIDTH, default 6, bbox count width.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset_N  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  core-fsm pulse, begin history read sweep.
REQ-008 SHALL have port frame_num  input  TOTAL_FRAME_NUM_WIDTH  current frame serial number.
REQ-009 SHALL have port num_of_history_frames  input  NUM_OF_HISTORY_FRAMES_WIDTH  history frames to sweep.
REQ-010 SHALL have port num_of_bbox_in_frame  input  NUM_OF_BBOX_IN_FRAME_WIDTH  valid bboxes per stored frame.
REQ-011 SHALL have port rd_en  output  1  one-cycle read strobe to buffer.
REQ-012 SHALL have port frame_to_read  output  TOTAL_FRAME_NUM_WIDTH  history frame being read.
REQ-013 SHALL have ports offset_0 / offset_1  output  NUM_OF_BBOX_IN_FRAME_WIDTH  bbox offsets of current line.
REQ-014 SHALL have ports data_in_0 / data_in_1  input  DATA_WIDTH  buffer read data, valid 1 cycle after rd_en.
REQ-015 SHALL have ports line_data_0 / line_data_1  output  DATA_WIDTH  captured line to similarity metric.
REQ-016 SHALL have ports line_valid  output  1, line_valid_1  output  1  line present / second word meaningful.
REQ-017 SHALL have port line_ready  input  1  similarity metric accepts line (read_new_line).
REQ-018 SHALL have ports busy  output  1, done_read  output  1  sweep active / one-cycle completion pulse.
REQ-019 SHALL have port counter_of_history_frame  output  NUM_OF_HISTORY_FRAMES_WIDTH  1-based index of frame being read.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT_DATA, PRESENT, DONE.
REQ-021 SHALL, in IDLE on start=1, latch frame_num, eff_frames = min(num_of_history_frames, frame_num), num_of_bbox_in_frame; set h=1, line=0; go ISSUE, or DONE if eff_frames=0 or bbox count=0.
REQ-022 SHALL, in ISSUE, assert rd_en one cycle with frame_to_read = latched frame_num - h (mod 2^TOTAL_FRAME_NUM_WIDTH), offset_0 = 2*line, offset_1 = 2*line+1; next WAIT_DATA.
REQ-023 SHALL, in WAIT_DATA, register data_in_0/1 into line_data_0/1 at the cycle end; next PRESENT.
REQ-024 SHALL, in PRESENT, hold line_valid=1 and line_data stable until line_ready=1; transfer occurs on the cycle line_valid & line_ready.
REQ-025 SHALL set line_valid_1 = 0 only on the last line of a frame when bbox count is odd, else 1.
REQ-026 SHALL, on transfer, advance line; if lines = ceil(bbox/2) exhausted, line=0 and h=h+1; if h exceeds eff_frames go DONE, else ISSUE.
REQ-027 SHALL pulse done_read for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL ignore start in any state other than IDLE.
REQ-029 SHALL drive counter_of_history_frame = h while busy, 0 in IDLE.
REQ-030 SHALL assert busy in every state except IDLE.
REQ-031 SHALL give minimum 3 cycles per line (ISSUE, WAIT_DATA, PRESENT with ready already high).
REQ-032 SHALL use latched inputs only; input changes mid-sweep have no effect.

Reset
REQ-033 SHALL on reset_N=0 immediately force IDLE and all outputs, counters and captured data to 0, including mid-sweep.
REQ-034 SHALL resume normal operation on the first rising clk edge after reset_N deasserts.

Verification
REQ-035 frame_num=5, history=2, bbox=4, ready=1 -> reads (frame 4, offs 0/1),(4,2/3),(3,0/1),(3,2/3), 4 transfers, done_read 12 cycles after ISSUE entry.
REQ-036 frame_num=1, history=3, bbox=3 -> only frame 0 read, 2 lines, last line line_valid_1=0, counter=1.
REQ-037 frame_num=0, history=3, start -> no rd_en, done_read one cycle after start cycle.
REQ-038 bbox=2, history=1, ready held 0 for 5 cycles in PRESENT -> line_valid and line_data stable 5 cycles, single transfer on ready.
REQ-039 frame_num=0x01 latched wrap check with history=2 on frame_num=0x01 clipped to 1; frame_num=0x00 after 255 rollover treated as REQ-037.
REQ-040 reset_N pulsed low during WAIT_DATA -> all outputs 0 same cycle, IDLE; fresh start completes normal sweep.

Source files
------------

// File: rtl/oflow_history_line_reader.sv
// Sweeps the stored history frames two bbox words per line, issuing buffer reads and
// handing each captured line to the similarity metric with a valid/ready handshake.
module oflow_history_line_reader #(
    parameter int DATA_WIDTH                  = 32,
    parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
    parameter int NUM_OF_BBOX_IN_FRAME_WIDTH  = 6
) (
    input  logic                                   clk,
    input  logic                                   reset_N,
    input  logic                                   start,
    input  logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_num,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  num_of_bbox_in_frame,
    output logic                                   rd_en,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0]       frame_to_read,
    output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  offset_0,
    output logic [NUM_OF_BBOX_IN_FRAME_WIDTH-1:0]  offset_1,
    input  logic [DATA_WIDTH-1:0]                  data_in_0,
    input  logic [DATA_WIDTH-1:0]                  data_in_1,
    output logic [DATA_WIDTH-1:0]                  line_data_0,
    output logic [DATA_WIDTH-1:0]                  line_data_1,
    output logic                                   line_valid,
    output logic                                   line_valid_1,
    input  logic                                   line_ready,
    output logic                                   busy,
    output logic                                   done_read,
    output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] counter_of_history_frame
);

    // state     | meaning
    // IDLE      | waiting for start
    // ISSUE     | one-cycle read strobe for current frame/line
    // WAIT_DATA | buffer returns data, captured at cycle end
    // PRESENT   | line held valid until the metric accepts it
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, PRESENT, DONE} state_t;

    localparam int F = TOTAL_FRAME_NUM_WIDTH;
    localparam int H = NUM_OF_HISTORY_FRAMES_WIDTH;
    localparam int B = NUM_OF_BBOX_IN_FRAME_WIDTH;
    localparam logic [H-1:0] H_ONE = 1;
    localparam logic [B-1:0] B_ONE = 1;

    state_t         state, state_nxt;
    logic [F-1:0]   frame_lat;
    logic [H-1:0]   eff_frames, eff_calc, h;
    logic [B-1:0]   bbox_lat, line, lines_per_frame;
    logic           last_line, last_frame, transfer;

    always_comb begin
        eff_calc = num_of_history_frames;
        if (frame_num < {{(F-H){1'b0}}, num_of_history_frames})
            eff_calc = frame_num[H-1:0];
    end

    assign lines_per_frame = (bbox_lat >> 1) + {{(B-1){1'b0}}, bbox_lat[0]};
    assign last_line       = (line == lines_per_frame - B_ONE);
    assign last_frame      = (h == eff_frames);
    assign transfer        = (state == PRESENT) && line_ready;

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:
                if (start) begin
                    if (eff_calc == '0 || num_of_bbox_in_frame == '0) state_nxt = DONE;
                    else                                               state_nxt = ISSUE;
                end
            ISSUE:     state_nxt = WAIT_DATA;
            WAIT_DATA: state_nxt = PRESENT;
            PRESENT:
                if (line_ready) state_nxt = (last_line && last_frame) ? DONE : ISSUE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // h is not bumped past the last frame so the counter still reads eff_frames in DONE
    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            frame_lat   <= '0;
            eff_frames  <= '0;
            bbox_lat    <= '0;
            h           <= '0;
            line        <= '0;
            line_data_0 <= '0;
            line_data_1 <= '0;
        end else begin
            if (state == IDLE && start) begin
                frame_lat  <= frame_num;
                eff_frames <= eff_calc;
                bbox_lat   <= num_of_bbox_in_frame;
                h          <= H_ONE;
                line       <= '0;
            end
            if (state == WAIT_DATA) begin
                line_data_0 <= data_in_0;
                line_data_1 <= data_in_1;
            end
            if (transfer) begin
                if (last_line) begin
                    line <= '0;
                    if (!last_frame) h <= h + H_ONE;
                end else begin
                    line <= line + B_ONE;
                end
            end
        end
    end

    assign busy          = (state != IDLE);
    assign rd_en         = (state == ISSUE);
    assign done_read     = (state == DONE);
    assign line_valid    = (state == PRESENT);
    assign line_valid_1  = (state == PRESENT) && !(last_line && bbox_lat[0]);
    assign frame_to_read = rd_en ? frame_lat - {{(F-H){1'b0}}, h} : '0;
    assign offset_0      = rd_en ? {line[B-2:0], 1'b0} : '0;
    assign offset_1      = rd_en ? {line[B-2:0], 1'b1} : '0;
    assign counter_of_history_frame = busy ? h : '0;

endmodule

// File: tb/tb_oflow_history_line_reader.sv
// Directed bench for oflow_history_line_reader: table of sweeps plus stall and reset sequences.
module tb_oflow_history_line_reader;

    logic        clk = 1'b0;
    logic        reset_N;
    logic        start;
    logic [7:0]  frame_num;
    logic [2:0]  num_of_history_frames;
    logic [5:0]  num_of_bbox_in_frame;
    logic        rd_en;
    logic [7:0]  frame_to_read;
    logic [5:0]  offset_0, offset_1;
    logic [31:0] data_in_0, data_in_1;
    logic [31:0] line_data_0, line_data_1;
    logic        line_valid, line_valid_1, line_ready;
    logic        busy, done_read;
    logic [2:0]  counter_of_history_frame;

    int compared = 0;
    int mismatched = 0;

    oflow_history_line_reader dut (
        .clk(clk), .reset_N(reset_N), .start(start), .frame_num(frame_num),
        .num_of_history_frames(num_of_history_frames), .num_of_bbox_in_frame(num_of_bbox_in_frame),
        .rd_en(rd_en), .frame_to_read(frame_to_read), .offset_0(offset_0), .offset_1(offset_1),
        .data_in_0(data_in_0), .data_in_1(data_in_1), .line_data_0(line_data_0),
        .line_data_1(line_data_1), .line_valid(line_valid), .line_valid_1(line_valid_1),
        .line_ready(line_ready), .busy(busy), .done_read(done_read),
        .counter_of_history_frame(counter_of_history_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] frame;
        logic [2:0] hist;
        logic [5:0] bbox;
        int         lines;
        logic [7:0] first_f;
        logic [7:0] last_f;
        logic [5:0] last_off;
        logic       last_lv1;
        logic [2:0] last_cnt;
        int         done_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // buffer contents are a function of the address so captured lines can be traced
    function automatic logic [31:0] mk(input bit which, input logic [7:0] f, input logic [5:0] o);
        return {7'h68, which, f, 10'h0, o};
    endfunction

    task automatic run_sweep(input vec_t v);
        int reads = 0, xfers = 0, cyc = 0;
        bit done_seen = 0;
        logic [7:0] first_f = '0, last_f = '0;
        logic [5:0] last_off = '0;
        logic last_lv1 = 1'b0;
        logic [2:0] cnt = '0;
        logic [31:0] exp_d0 = '0, exp_d1 = '0;
        @(negedge clk);
        frame_num = v.frame; num_of_history_frames = v.hist; num_of_bbox_in_frame = v.bbox;
        line_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        frame_num = 8'hEE; num_of_history_frames = 3'd5; num_of_bbox_in_frame = 6'd9;
        while (!done_seen && cyc < 200) begin
            if (rd_en) begin
                reads++;
                if (reads == 1) first_f = frame_to_read;
                last_f = frame_to_read;
                last_off = offset_0;
                chk("offset_pair", {26'h0, offset_1}, {26'h0, offset_0 + 6'd1});
                exp_d0 = mk(1'b0, frame_to_read, offset_0);
                exp_d1 = mk(1'b1, frame_to_read, offset_1);
                data_in_0 = exp_d0; data_in_1 = exp_d1;
            end
            if (line_valid && line_ready) begin
                xfers++;
                chk("line_data_0", line_data_0, exp_d0);
                chk("line_data_1", line_data_1, exp_d1);
                last_lv1 = line_valid_1;
                cnt = counter_of_history_frame;
            end
            if (done_read) begin
                done_seen = 1;
                chk("done_cycle", cyc, v.done_cyc);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
        chk("rd_en_count", reads, v.lines);
        chk("transfer_count", xfers, v.lines);
        if (v.lines > 0) begin
            chk("first_frame", first_f, v.first_f);
            chk("last_frame", last_f, v.last_f);
            chk("last_offset_0", last_off, v.last_off);
            chk("last_line_valid_1", last_lv1, v.last_lv1);
            chk("counter_last", cnt, v.last_cnt);
        end
        @(negedge clk);
        chk("idle_after_done", {busy, done_read, counter_of_history_frame}, 0);
    endtask

    initial begin
        //         frame  hist  bbox  lines first last  off  lv1  cnt  done
        vecs[0] = '{8'd5,   3'd2, 6'd4, 4,  8'd4,   8'd3,   6'd2, 1'b1, 3'd2, 12};
        vecs[1] = '{8'd1,   3'd3, 6'd3, 2,  8'd0,   8'd0,   6'd2, 1'b0, 3'd1, 6};
        vecs[2] = '{8'd0,   3'd3, 6'd4, 0,  8'd0,   8'd0,   6'd0, 1'b0, 3'd0, 0};
        vecs[3] = '{8'h01,  3'd2, 6'd2, 1,  8'd0,   8'd0,   6'd0, 1'b1, 3'd1, 3};
        vecs[4] = '{8'h00,  3'd2, 6'd2, 0,  8'd0,   8'd0,   6'd0, 1'b0, 3'd0, 0};
        vecs[5] = '{8'd200, 3'd7, 6'd5, 21, 8'd199, 8'd193, 6'd4, 1'b0, 3'd7, 63};
        vecs[6] = '{8'd10,  3'd0, 6'd4, 0,  8'd0,   8'd0,   6'd0, 1'b0, 3'd0, 0};
        vecs[7] = '{8'd3,   3'd4, 6'd1, 3,  8'd2,   8'd0,   6'd0, 1'b0, 3'd3, 9};

        reset_N = 1'b0; start = 1'b0; frame_num = '0; num_of_history_frames = '0;
        num_of_bbox_in_frame = '0; data_in_0 = '0; data_in_1 = '0; line_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, rd_en, line_valid, line_valid_1, done_read}, 0);
        chk("reset_data", line_data_0 | line_data_1, 0);
        chk("reset_addr", {frame_to_read, offset_0, offset_1, counter_of_history_frame}, 0);
        reset_N = 1'b1;

        for (int i = 0; i < 8; i++) run_sweep(vecs[i]);

        // stall in PRESENT: line must stay put until ready
        begin
            int guard = 0;
            @(negedge clk);
            frame_num = 8'd9; num_of_history_frames = 3'd1; num_of_bbox_in_frame = 6'd2;
            line_ready = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (!line_valid && guard < 20) begin
                if (rd_en) begin
                    data_in_0 = mk(1'b0, frame_to_read, offset_0);
                    data_in_1 = mk(1'b1, frame_to_read, offset_1);
                end
                @(negedge clk);
                guard++;
            end
            chk("stall_reach_present", guard < 20, 1);
            for (int k = 0; k < 5; k++) begin
                chk("stall_line_valid", line_valid, 1);
                chk("stall_line_data_0", line_data_0, mk(1'b0, 8'd8, 6'd0));
                chk("stall_line_data_1", line_data_1, mk(1'b1, 8'd8, 6'd1));
                if (k < 4) @(negedge clk);
            end
            line_ready = 1'b1;
            @(negedge clk);
            chk("stall_single_transfer", {line_valid, done_read}, 2'b01);
            @(negedge clk);
        end

        // reset asserted mid-sweep while waiting for buffer data
        begin
            int guard = 0;
            @(negedge clk);
            frame_num = 8'd5; num_of_history_frames = 3'd2; num_of_bbox_in_frame = 6'd4;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            while (!rd_en && guard < 10) begin @(negedge clk); guard++; end
            @(negedge clk);
            chk("pre_reset_wait_data", {busy, rd_en, line_valid}, 3'b100);
            #2 reset_N = 1'b0;
            #1;
            chk("midreset_ctrl", {busy, rd_en, line_valid, line_valid_1, done_read}, 0);
            chk("midreset_data", line_data_0 | line_data_1, 0);
            chk("midreset_cnt", counter_of_history_frame, 0);
            @(negedge clk);
            reset_N = 1'b1;
            run_sweep(vecs[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
